rps_round_ctrl: RTL and testbench

Round sequencer for the rock-paper-scissors learning game. Each round it obtains the CPU's move from the Markov predictor before the player commits, then accepts the player's move. It judges the round, updates the scores, and feeds the observed transition back to the predictor. It sits between the debounced KEY/SW front end, the predictor, and the HEX/LEDR display logic.

---
 rtl/rps_pkg.sv | 44 ++++
 rtl/rps_judge.sv | 24 ++
 rtl/rps_round_ctrl.sv | 173 +++++++++++++++++
 tb/tb_rps_round_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rps_pkg.sv
// Shared definitions for the rock-paper-scissors round logic: move and result
// encodings, state enum and the small helper functions used by the FSM and judge.
package rps_pkg;

    localparam logic [1:0] ROCK     = 2'b00;
    localparam logic [1:0] SCISSORS = 2'b01;
    localparam logic [1:0] PAPER    = 2'b10;
    localparam logic [1:0] ILLEGAL  = 2'b11;

    localparam logic [1:0] RES_NONE   = 2'b00;
    localparam logic [1:0] RES_PLAYER = 2'b01;
    localparam logic [1:0] RES_CPU    = 2'b10;
    localparam logic [1:0] RES_TIE    = 2'b11;

    localparam logic [3:0] NO_HIST   = 4'd9;
    localparam logic [6:0] SCORE_MAX = 7'd127;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_PREDICT   = 3'd1,
        ST_WAIT_MOVE = 3'd2,
        ST_JUDGE     = 3'd3,
        ST_UPDATE    = 3'd4,
        ST_SHOW      = 3'd5,
        ST_DONE      = 3'd6
    } rps_state_e;

    // True when move a defeats move b.
    function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
        return ((a == ROCK)     && (b == SCISSORS)) ||
               ((a == SCISSORS) && (b == PAPER))    ||
               ((a == PAPER)    && (b == ROCK));
    endfunction

    // Predictor context for a judged (player, cpu) pair: 3*player + cpu.
    function automatic logic [3:0] ctx_of(input logic [1:0] player, input logic [1:0] cpu);
        return ({2'b00, player} << 1) + {2'b00, player} + {2'b00, cpu};
    endfunction

    function automatic logic [6:0] sat_inc(input logic [6:0] v);
        return (v == SCORE_MAX) ? v : v + 7'd1;
    endfunction

endpackage

// File: rtl/rps_judge.sv
// Combinational round judge: (player, cpu) -> result code. Shared with the display
// logic, so an illegal move on either side yields RES_NONE rather than a verdict.
module rps_judge
    import rps_pkg::*;
(
    input  logic [1:0] player_i,
    input  logic [1:0] cpu_i,
    output logic [1:0] result_o
);

    always_comb begin
        result_o = RES_NONE;
        if ((player_i != ILLEGAL) && (cpu_i != ILLEGAL)) begin
            if (player_i == cpu_i) begin
                result_o = RES_TIE;
            end else if (beats(player_i, cpu_i)) begin
                result_o = RES_PLAYER;
            end else begin
                result_o = RES_CPU;
            end
        end
    end

endmodule

// File: rtl/rps_round_ctrl.sv
// Round sequencer: fetches the CPU move from the predictor, takes the player's move,
// judges and scores the round, then reports the observed transition back.
module rps_round_ctrl
    import rps_pkg::*;
#(
    parameter int ROUNDS_MAX  = 60,
    parameter int SHOW_CYCLES = 4
)
(
    input  logic       clock,
    input  logic       reset,
    input  logic       pred_init_done,
    output logic       pred_req,
    output logic [3:0] pred_ctx,
    input  logic       pred_ack,
    input  logic [1:0] pred_choice,
    output logic       upd_valid,
    output logic [3:0] upd_ctx,
    output logic [1:0] upd_move,
    input  logic       upd_ready,
    input  logic       move_valid,
    input  logic [1:0] move,
    output logic [1:0] cpu_move,
    output logic [1:0] result,
    output logic [6:0] player_score,
    output logic [6:0] cpu_score,
    output logic [6:0] tie_count,
    output logic [5:0] round_count,
    output logic       illegal,
    output logic       busy,
    output logic       game_over,
    output logic [2:0] dbg_state
);

    localparam int         SHOW_W    = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [SHOW_W-1:0] SHOW_LAST = SHOW_W'(SHOW_CYCLES - 1);
    localparam logic [5:0] ROUNDS_END = 6'(ROUNDS_MAX);

    rps_state_e        state_q;
    logic              pred_req_q;
    logic [1:0]        choice_q;
    logic [1:0]        move_q;
    logic [3:0]        ctx_q;
    logic              upd_valid_q;
    logic [3:0]        upd_ctx_q;
    logic [1:0]        upd_move_q;
    logic [1:0]        cpu_move_q;
    logic [1:0]        result_q;
    logic [6:0]        player_score_q;
    logic [6:0]        cpu_score_q;
    logic [6:0]        tie_count_q;
    logic [5:0]        round_count_q;
    logic              illegal_q;
    logic [SHOW_W-1:0] show_cnt_q;
    logic [1:0]        judge_res;

    rps_judge u_judge (
        .player_i (move_q),
        .cpu_i    (choice_q),
        .result_o (judge_res)
    );

    // Both predictor links are valid/ready style: a request or update is raised
    // from a register, held with stable payload, and retired on the edge where
    // the partner's ack/ready is sampled high. pred_req and upd_valid live in
    // disjoint states, so they are never high together.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= ST_INIT;
            pred_req_q     <= 1'b0;
            choice_q       <= ROCK;
            move_q         <= ROCK;
            ctx_q          <= NO_HIST;
            upd_valid_q    <= 1'b0;
            upd_ctx_q      <= 4'd0;
            upd_move_q     <= ROCK;
            cpu_move_q     <= ROCK;
            result_q       <= RES_NONE;
            player_score_q <= 7'd0;
            cpu_score_q    <= 7'd0;
            tie_count_q    <= 7'd0;
            round_count_q  <= 6'd0;
            illegal_q      <= 1'b0;
            show_cnt_q     <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (pred_init_done) begin
                        state_q    <= ST_PREDICT;
                        pred_req_q <= 1'b1;
                    end
                end
                ST_PREDICT: begin
                    if (pred_ack) begin
                        choice_q   <= pred_choice;
                        pred_req_q <= 1'b0;
                        state_q    <= ST_WAIT_MOVE;
                    end
                end
                ST_WAIT_MOVE: begin
                    if (move_valid) begin
                        if (move == ILLEGAL) begin
                            illegal_q <= 1'b1;
                        end else begin
                            illegal_q <= 1'b0;
                            move_q    <= move;
                            state_q   <= ST_JUDGE;
                        end
                    end
                end
                ST_JUDGE: begin
                    cpu_move_q <= choice_q;
                    result_q   <= judge_res;
                    case (judge_res)
                        RES_PLAYER: player_score_q <= sat_inc(player_score_q);
                        RES_CPU:    cpu_score_q    <= sat_inc(cpu_score_q);
                        RES_TIE:    tie_count_q    <= sat_inc(tie_count_q);
                        default:    ;
                    endcase
                    round_count_q <= round_count_q + 6'd1;
                    upd_ctx_q     <= ctx_q;
                    upd_move_q    <= move_q;
                    // The first round of a game has no prior context to report.
                    upd_valid_q   <= (ctx_q != NO_HIST);
                    ctx_q         <= ctx_of(move_q, choice_q);
                    state_q       <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    if (!upd_valid_q || upd_ready) begin
                        upd_valid_q <= 1'b0;
                        show_cnt_q  <= '0;
                        state_q     <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (show_cnt_q == SHOW_LAST) begin
                        if (round_count_q == ROUNDS_END) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q    <= ST_PREDICT;
                            pred_req_q <= 1'b1;
                        end
                    end else begin
                        show_cnt_q <= show_cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign pred_req     = pred_req_q;
    assign pred_ctx     = ctx_q;
    assign upd_valid    = upd_valid_q;
    assign upd_ctx      = upd_ctx_q;
    assign upd_move     = upd_move_q;
    assign cpu_move     = cpu_move_q;
    assign result       = result_q;
    assign player_score = player_score_q;
    assign cpu_score    = cpu_score_q;
    assign tie_count    = tie_count_q;
    assign round_count  = round_count_q;
    assign illegal      = illegal_q;
    assign busy         = (state_q != ST_WAIT_MOVE) && (state_q != ST_DONE);
    assign game_over    = (state_q == ST_DONE);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_rps_round_ctrl.sv
// Bench for rps_round_ctrl: directed rounds from the game rules plus randomized
// games, all checked against a round-level model of scores, context and timing.
module tb_rps_round_ctrl;

    localparam int RM = 6;
    localparam int SC = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       pred_init_done;
    logic       pred_req;
    logic [3:0] pred_ctx;
    logic       pred_ack;
    logic [1:0] pred_choice;
    logic       upd_valid;
    logic [3:0] upd_ctx;
    logic [1:0] upd_move;
    logic       upd_ready;
    logic       move_valid;
    logic [1:0] move;
    logic [1:0] cpu_move;
    logic [1:0] result;
    logic [6:0] player_score;
    logic [6:0] cpu_score;
    logic [6:0] tie_count;
    logic [5:0] round_count;
    logic       illegal;
    logic       busy;
    logic       game_over;
    logic [2:0] dbg_state;

    rps_round_ctrl #(.ROUNDS_MAX(RM), .SHOW_CYCLES(SC)) dut (
        .clock          (clock),
        .reset          (reset),
        .pred_init_done (pred_init_done),
        .pred_req       (pred_req),
        .pred_ctx       (pred_ctx),
        .pred_ack       (pred_ack),
        .pred_choice    (pred_choice),
        .upd_valid      (upd_valid),
        .upd_ctx        (upd_ctx),
        .upd_move       (upd_move),
        .upd_ready      (upd_ready),
        .move_valid     (move_valid),
        .move           (move),
        .cpu_move       (cpu_move),
        .result         (result),
        .player_score   (player_score),
        .cpu_score      (cpu_score),
        .tie_count      (tie_count),
        .round_count    (round_count),
        .illegal        (illegal),
        .busy           (busy),
        .game_over      (game_over),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int overlap_seen = 0;

    // Model state: tallies for the current game.
    int m_player, m_cpu, m_tie, m_rounds, m_ctx, m_cpu_shown, m_result;

    always @(negedge clock) begin
        if (reset && pred_req && upd_valid) overlap_seen++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Player (0 rock, 1 scissors, 2 paper) wins when the cpu holds the next move.
    function automatic int ref_result(input int p, input int c);
        if (p == c) return 3;
        if (c == (p + 1) % 3) return 1;
        return 2;
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // ---------------- driver tasks ----------------
    task automatic reset_and_check(input int edges);
        @(negedge clock);
        reset = 1'b0;
        pred_init_done = 1'b0;
        pred_ack = 1'b0;
        pred_choice = 2'd0;
        upd_ready = 1'b0;
        move_valid = 1'b0;
        move = 2'd0;
        repeat (edges) step();
        m_player = 0; m_cpu = 0; m_tie = 0; m_rounds = 0;
        m_ctx = 9; m_cpu_shown = 0; m_result = 0;
        check("rst_pred_req", pred_req, 0);
        check("rst_upd_valid", upd_valid, 0);
        check("rst_busy", busy, 1);
        check("rst_game_over", game_over, 0);
        check("rst_illegal", illegal, 0);
        check("rst_result", result, 0);
        check("rst_cpu_move", cpu_move, 0);
        check("rst_counts", {player_score, cpu_score, tie_count, round_count}, 0);
        check("rst_pred_ctx", pred_ctx, 9);
        reset = 1'b1;
        step();
        check("init_waits", {pred_req, busy}, 2'b01);
    endtask

    task automatic play_round(input int cpu, input int pm, input int ack_delay,
                              input int ready_delay, input int n_illegal,
                              input bit junk, input bit abort);
        int n;
        int prev_ctx;
        int exp_edges;
        bit exp_upd;
        n = 0;
        while (!pred_req && n < 40) begin
            step();
            n++;
        end
        check("pred_req_seen", pred_req, 1);
        check("pred_ctx", pred_ctx, m_ctx);
        for (int i = 0; i < ack_delay; i++) begin
            if (junk && i == 0) begin
                move_valid = 1'b1;
                move = 2'(pm);
            end
            step();
            move_valid = 1'b0;
            check("pred_hold", {pred_req, upd_valid}, 2'b10);
        end
        pred_ack = 1'b1;
        pred_choice = 2'(cpu);
        step();
        pred_ack = 1'b0;
        pred_choice = 2'($urandom_range(0, 3));
        check("pred_req_drop", pred_req, 0);
        check("wait_busy", busy, 0);
        check("cpu_hidden", cpu_move, m_cpu_shown);
        check("rounds_pre", round_count, m_rounds);
        for (int i = 0; i < n_illegal; i++) begin
            move_valid = 1'b1;
            move = 2'b11;
            step();
            move_valid = 1'b0;
            check("illegal_set", {illegal, busy}, 2'b10);
        end
        move_valid = 1'b1;
        move = 2'(pm);
        step();
        move_valid = 1'b0;
        check("illegal_clr", {illegal, busy}, 2'b01);
        step();
        m_result = ref_result(pm, cpu);
        if (m_result == 1) m_player++;
        else if (m_result == 2) m_cpu++;
        else m_tie++;
        m_rounds++;
        prev_ctx = m_ctx;
        m_ctx = 3 * pm + cpu;
        m_cpu_shown = cpu;
        exp_upd = (prev_ctx != 9);
        check("result", result, m_result);
        check("cpu_move", cpu_move, cpu);
        check("player_score", player_score, m_player);
        check("cpu_score", cpu_score, m_cpu);
        check("tie_count", tie_count, m_tie);
        check("round_count", round_count, m_rounds);
        check("upd_valid", upd_valid, exp_upd);
        if (exp_upd) check("upd_payload", {upd_ctx, upd_move}, {4'(prev_ctx), 2'(pm)});
        if (abort && exp_upd) return;
        if (exp_upd) begin
            for (int i = 0; i < ready_delay; i++) begin
                step();
                check("upd_hold", {upd_valid, upd_ctx, upd_move}, {1'b1, 4'(prev_ctx), 2'(pm)});
            end
            upd_ready = 1'b1;
            step();
            upd_ready = 1'b0;
            check("upd_drop", upd_valid, 0);
            exp_edges = SC;
        end else begin
            exp_edges = SC + 1;
        end
        n = 0;
        while (!pred_req && !game_over && n < 40) begin
            if (junk && n == 0) begin
                move_valid = 1'b1;
                move = 2'((pm + 1) % 3);
            end
            step();
            move_valid = 1'b0;
            n++;
        end
        check("show_len", n, exp_edges);
        check("game_over", game_over, (m_rounds == RM));
        check("rounds_post", round_count, m_rounds);
    endtask

    task automatic done_checks();
        move_valid = 1'b1;
        move = 2'd1;
        step();
        move_valid = 1'b0;
        step();
        check("done_rounds", round_count, RM);
        check("done_hold", {game_over, busy, result}, {1'b1, 1'b0, 2'(m_result)});
        check("done_scores", {player_score, cpu_score, tie_count},
              {7'(m_player), 7'(m_cpu), 7'(m_tie)});
    endtask

    task automatic random_game();
        while (m_rounds < RM) begin
            play_round($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3),
                       $urandom_range(0, 4), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
        end
        done_checks();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c;
        reset = 1'b0;
        pred_init_done = 1'b0;
        pred_ack = 1'b0;
        pred_choice = 2'd0;
        upd_ready = 1'b0;
        move_valid = 1'b0;
        move = 2'd0;

        reset_and_check(2);
        pred_init_done = 1'b1;
        play_round(2, 0, 0, 0, 0, 1'b0, 1'b0);   // cpu paper beats rock, no update
        play_round(0, 2, 1, 5, 0, 1'b0, 1'b0);   // paper beats rock, update ctx 2
        play_round(1, 1, 2, 0, 2, 1'b1, 1'b0);   // illegal twice, then scissors tie
        random_game();

        reset_and_check(2);
        pred_init_done = 1'b1;
        while (m_rounds < RM) begin
            c = $urandom_range(0, 2);
            play_round(c, c, $urandom_range(0, 2), $urandom_range(0, 2), 0, 1'b0, 1'b0);
        end
        check("all_ties", tie_count, RM);
        done_checks();

        reset_and_check(2);
        pred_init_done = 1'b1;
        play_round(1, 0, 0, 0, 0, 1'b0, 1'b0);
        play_round(0, 0, 0, 0, 0, 1'b0, 1'b1);
        check("abort_pending", upd_valid, 1);
        reset_and_check(1);
        pred_init_done = 1'b1;
        random_game();

        reset_and_check(2);
        pred_init_done = 1'b1;
        random_game();

        check("no_overlap", overlap_seen, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
